// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the load/store unit and its lane aligner.
package mem_access_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      MERGE = 3'd2,
      WRITE = 3'd3,
      RESP  = 3'd4
   } state_t;

   // Reserved size is never a legal access.
   function automatic logic is_misaligned(input size_t size, input logic [1:0] lo);
      logic mis;
      case (size)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = lo[0];
         SZ_WORD: mis = (lo != 2'b00);
         default: mis = 1'b1;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge (little-endian).
module mem_lane_align
   import mem_access_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic        is_unsigned,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [4:0]  byte_sh;
   logic [4:0]  half_sh;

   assign byte_sh = {lane, 3'b000};
   assign half_sh = {lane[1], 4'b0000};
   assign byte_v  = word[byte_sh +: 8];
   assign half_v  = word[half_sh +: 16];

   // Select and extend the addressed lane; splice store data into the old word.
   always_comb begin
      load_data = word;
      merged    = wdata;
      case (size)
         SZ_BYTE: begin
            load_data = {{24{~is_unsigned & byte_v[7]}}, byte_v};
            merged    = word;
            merged[byte_sh +: 8] = wdata[7:0];
         end
         SZ_HALF: begin
            load_data = {{16{~is_unsigned & half_v[15]}}, half_v};
            merged    = word;
            merged[half_sh +: 16] = wdata[15:0];
         end
         default: begin
            load_data = word;
            merged    = wdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a word-wide asynchronous-read data memory.
// Sub-word stores are done as read-modify-write; one request in flight at a time.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int DATA_SIZE  = 32,
   parameter int SELEC_SIZE = 16,
   parameter int ADDR_SIZE  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_SIZE-1:0]  req_addr,
   input  logic [DATA_SIZE-1:0]  req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_SIZE-1:0]  rsp_rdata,
   output logic                  rsp_misaligned,
   output logic                  dm_we,
   output logic [SELEC_SIZE-1:0] dm_address,
   output logic [DATA_SIZE-1:0]  dm_d,
   input  logic [DATA_SIZE-1:0]  dm_q
);

   state_t      state_q, state_d;
   logic [1:0]  size_q;
   logic [1:0]  lane_q;
   logic        uns_q;
   logic        req_mis;
   logic [31:0] load_data;
   logic [31:0] merged;

   // Upper address bits alias onto the same memory words.
   logic unused_addr;
   assign unused_addr = ^req_addr[ADDR_SIZE-1:SELEC_SIZE+2];

   assign req_mis   = is_misaligned(size_t'(req_size), req_addr[1:0]);
   assign req_ready = (state_q == IDLE) && !rst;
   assign rsp_valid = (state_q == RESP) && !rst;
   // Reset in a WRITE cycle must not corrupt memory.
   assign dm_we     = (state_q == WRITE) && !rst;

   // dm_d already holds the store data latched at accept, so it feeds the merge.
   mem_lane_align u_align (
      .size        (size_q),
      .lane        (lane_q),
      .is_unsigned (uns_q),
      .word        (dm_q),
      .wdata       (dm_d),
      .load_data   (load_data),
      .merged      (merged)
   );

   // Next-state: route each accepted request through its operation sequence.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (req_mis)                      state_d = RESP;
               else if (!req_we)                 state_d = LOAD;
               else if (req_size == SZ_WORD)     state_d = WRITE;
               else                              state_d = MERGE;
            end
         end
         LOAD:    state_d = RESP;
         MERGE:   state_d = WRITE;
         WRITE:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, latched request fields, memory drive and held response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         size_q         <= 2'b00;
         lane_q         <= 2'b00;
         uns_q          <= 1'b0;
         dm_address     <= '0;
         dm_d           <= '0;
         rsp_rdata      <= '0;
         rsp_misaligned <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  size_q     <= req_size;
                  lane_q     <= req_addr[1:0];
                  uns_q      <= req_unsigned;
                  dm_address <= req_addr[SELEC_SIZE+1:2];
                  dm_d       <= req_wdata;
                  if (req_mis) begin
                     rsp_rdata      <= '0;
                     rsp_misaligned <= 1'b1;
                  end
               end
            end
            LOAD: begin
               rsp_rdata      <= load_data;
               rsp_misaligned <= 1'b0;
            end
            MERGE: begin
               dm_d <= merged;
            end
            WRITE: begin
               rsp_rdata      <= '0;
               rsp_misaligned <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
